// File: rtl/jtag_debug_cmd_exec.sv
// Executes host debug commands delivered through the PIO toggle handshake:
// core halt/resume/step, register access and word-wide memory access.
module jtag_debug_cmd_exec #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] arg_in,
  input  logic [7:0]  cmd_in,
  output logic [31:0] result_out,
  output logic [7:0]  status_out,
  output logic        dbg_halt_req,
  input  logic        dbg_halted,
  output logic        dbg_step_req,
  input  logic        dbg_step_done,
  output logic [4:0]  dbg_reg_idx,
  output logic        dbg_reg_we,
  output logic [31:0] dbg_reg_wdata,
  input  logic [31:0] dbg_reg_rdata,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest
);

  typedef enum logic [2:0] {
    IDLE, EXEC, MEM_WAIT, REG_WAIT, STEP_WAIT, HALT_WAIT, DONE
  } state_t;

  localparam logic [3:0] OP_NOP      = 4'd0;
  localparam logic [3:0] OP_HALT     = 4'd1;
  localparam logic [3:0] OP_RESUME   = 4'd2;
  localparam logic [3:0] OP_STEP     = 4'd3;
  localparam logic [3:0] OP_SET_ADDR = 4'd4;
  localparam logic [3:0] OP_WR_MEM   = 4'd5;
  localparam logic [3:0] OP_RD_MEM   = 4'd6;
  localparam logic [3:0] OP_RD_REG   = 4'd7;
  localparam logic [3:0] OP_WR_REG   = 4'd8;

  // The wait counter starts at 0 on entry, so abort when it has seen TIMEOUT stalled cycles.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        last_go;
  logic [3:0]  opcode;
  logic [31:0] arg_reg;
  logic [31:0] addr_reg;
  logic [7:0]  wait_cnt;
  logic        busy;
  logic        error;
  logic        ack;
  logic        halted_mirror;

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_in[6:4];

  assign status_out = {ack, 4'b0000, halted_mirror, error, busy};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      last_go       <= 1'b0;
      opcode        <= 4'd0;
      arg_reg       <= 32'd0;
      addr_reg      <= 32'd0;
      wait_cnt      <= 8'd0;
      busy          <= 1'b0;
      error         <= 1'b0;
      ack           <= 1'b0;
      halted_mirror <= 1'b0;
      result_out    <= 32'd0;
      dbg_halt_req  <= 1'b0;
      dbg_step_req  <= 1'b0;
      dbg_reg_idx   <= 5'd0;
      dbg_reg_we    <= 1'b0;
      dbg_reg_wdata <= 32'd0;
      m_address     <= 32'd0;
      m_read        <= 1'b0;
      m_write       <= 1'b0;
      m_writedata   <= 32'd0;
    end else begin
      halted_mirror <= dbg_halted;
      dbg_step_req  <= 1'b0;
      dbg_reg_we    <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_in[7] != last_go) begin
            last_go <= cmd_in[7];
            busy    <= 1'b1;
            error   <= 1'b0;
            opcode  <= cmd_in[3:0];
            arg_reg <= arg_in;
            state   <= EXEC;
          end
        end

        EXEC: begin
          state <= DONE;
          case (opcode)
            OP_NOP: ;
            OP_HALT: begin
              dbg_halt_req <= 1'b1;
              state        <= HALT_WAIT;
            end
            OP_RESUME: dbg_halt_req <= 1'b0;
            OP_STEP: begin
              if (!dbg_halted) begin
                error <= 1'b1;
              end else begin
                dbg_step_req <= 1'b1;
                wait_cnt     <= 8'd0;
                state        <= STEP_WAIT;
              end
            end
            OP_SET_ADDR: begin
              addr_reg   <= {arg_reg[31:2], 2'b00};
              result_out <= {arg_reg[31:2], 2'b00};
            end
            OP_WR_MEM: begin
              m_write     <= 1'b1;
              m_address   <= addr_reg;
              m_writedata <= arg_reg;
              wait_cnt    <= 8'd0;
              state       <= MEM_WAIT;
            end
            OP_RD_MEM: begin
              m_read    <= 1'b1;
              m_address <= addr_reg;
              wait_cnt  <= 8'd0;
              state     <= MEM_WAIT;
            end
            OP_RD_REG: begin
              if (!dbg_halted) begin
                error <= 1'b1;
              end else begin
                dbg_reg_idx <= arg_reg[4:0];
                state       <= REG_WAIT;
              end
            end
            OP_WR_REG: begin
              if (!dbg_halted) begin
                error <= 1'b1;
              end else begin
                dbg_reg_idx   <= addr_reg[6:2];
                dbg_reg_wdata <= arg_reg;
                dbg_reg_we    <= 1'b1;
              end
            end
            default: error <= 1'b1;
          endcase
        end

        MEM_WAIT: begin
          if (!m_waitrequest) begin
            if (m_read) result_out <= m_readdata;
            m_read   <= 1'b0;
            m_write  <= 1'b0;
            addr_reg <= addr_reg + 32'd4;
            state    <= DONE;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            m_read  <= 1'b0;
            m_write <= 1'b0;
            error   <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        REG_WAIT: begin
          result_out <= dbg_reg_rdata;
          state      <= DONE;
        end

        STEP_WAIT: begin
          if (dbg_step_done) begin
            state <= DONE;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            error <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        HALT_WAIT: if (dbg_halted) state <= DONE;

        DONE: begin
          ack   <= last_go;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_debug_cmd_exec.sv
// Scoreboard bench for jtag_debug_cmd_exec: stimulus queues expected acks and
// bus transfers; negedge monitors pop and compare what the DUT presents.
module tb_jtag_debug_cmd_exec;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] arg_in = 32'd0;
  logic [7:0]  cmd_in = 8'd0;
  logic [31:0] result_out;
  logic [7:0]  status_out;
  logic        dbg_halt_req;
  logic        dbg_halted = 1'b0;
  logic        dbg_step_req;
  logic        dbg_step_done = 1'b0;
  logic [4:0]  dbg_reg_idx;
  logic        dbg_reg_we;
  logic [31:0] dbg_reg_wdata;
  logic [31:0] dbg_reg_rdata = 32'h0000_1234;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_waitrequest = 1'b0;

  always #5 clk = ~clk;

  // Memory slave returns a value derived from the address so reads are predictable.
  assign m_readdata = m_address ^ 32'hA5A5_0000;

  jtag_debug_cmd_exec #(.TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n), .arg_in(arg_in), .cmd_in(cmd_in),
    .result_out(result_out), .status_out(status_out),
    .dbg_halt_req(dbg_halt_req), .dbg_halted(dbg_halted),
    .dbg_step_req(dbg_step_req), .dbg_step_done(dbg_step_done),
    .dbg_reg_idx(dbg_reg_idx), .dbg_reg_we(dbg_reg_we),
    .dbg_reg_wdata(dbg_reg_wdata), .dbg_reg_rdata(dbg_reg_rdata),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest)
  );

  typedef struct {
    string       name;
    logic [31:0] result;
    logic [7:0]  status;
    int          lat;
    int          issue;
  } resp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          len;
  } bus_t;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } regw_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  regw_t regw_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int acks_seen = 0;
  int stall_left = 0;
  int halt_cnt = 0;
  int step_cd = 0;
  int step_hi = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Ack monitor
  logic  prev_ack = 1'b0;
  resp_t mon_r;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_ack = 1'b0;
    end else if (status_out[7] != prev_ack) begin
      prev_ack = status_out[7];
      acks_seen++;
      if (resp_q.size() == 0) begin
        check("unexpected_ack", 64'(status_out), 64'(status_out ^ 8'h80));
      end else begin
        mon_r = resp_q.pop_front();
        check({mon_r.name, "_result"}, 64'(result_out), 64'(mon_r.result));
        check({mon_r.name, "_status"}, 64'(status_out), 64'(mon_r.status));
        if (mon_r.lat >= 0)
          check({mon_r.name, "_latency"}, 64'(cycle - mon_r.issue - 1), 64'(mon_r.lat));
        $display("ack %-10s result=0x%08h status=0x%02h latency=%0d", mon_r.name,
                 result_out, status_out, cycle - mon_r.issue - 1);
      end
    end
  end

  // Bus monitor: one entry per m_read/m_write burst, plus register write strobes
  int          run_len = 0;
  logic        run_wr = 1'b0;
  logic [31:0] run_addr = 32'd0;
  logic [31:0] run_data = 32'd0;
  bus_t        bus_r;
  regw_t       reg_r;
  always @(negedge clk) begin
    if (m_read || m_write) begin
      if (run_len == 0) begin
        run_wr   = m_write;
        run_addr = m_address;
        run_data = m_writedata;
      end
      run_len++;
    end else if (run_len > 0) begin
      if (bus_q.size() == 0) begin
        check("unexpected_bus", 64'(run_len), 64'd0);
      end else begin
        bus_r = bus_q.pop_front();
        check("bus_kind", 64'(run_wr), 64'(bus_r.wr));
        check("bus_addr", 64'(run_addr), 64'(bus_r.addr));
        if (bus_r.wr) check("bus_wdata", 64'(run_data), 64'(bus_r.data));
        if (bus_r.len >= 0) check("bus_cycles", 64'(run_len), 64'(bus_r.len));
        $display("bus %s addr=0x%08h data=0x%08h cycles=%0d", run_wr ? "WR" : "RD",
                 run_addr, run_wr ? run_data : m_readdata, run_len);
      end
      run_len = 0;
    end
    if (dbg_reg_we) begin
      if (regw_q.size() == 0) begin
        check("unexpected_reg_we", 64'(dbg_reg_idx), 64'hFFFF);
      end else begin
        reg_r = regw_q.pop_front();
        check("reg_idx", 64'(dbg_reg_idx), 64'(reg_r.idx));
        check("reg_wdata", 64'(dbg_reg_wdata), 64'(reg_r.data));
        $display("reg WR idx=%0d data=0x%08h", dbg_reg_idx, dbg_reg_wdata);
      end
    end
  end

  // Slave stall, core halt and single-step responders
  always @(negedge clk) begin
    if ((m_read || m_write) && stall_left > 0) begin
      m_waitrequest = 1'b1;
      stall_left--;
    end else begin
      m_waitrequest = 1'b0;
    end

    if (dbg_halt_req != dbg_halted) begin
      halt_cnt++;
      if (halt_cnt == 3) begin
        dbg_halted = dbg_halt_req;
        halt_cnt = 0;
      end
    end else begin
      halt_cnt = 0;
    end

    dbg_step_done = 1'b0;
    if (step_cd > 0) begin
      step_cd--;
      if (step_cd == 0) dbg_step_done = 1'b1;
    end
    if (dbg_step_req) begin
      step_cd = 4;
      step_hi++;
    end
  end

  task automatic issue(input string name, input logic [7:0] cmd, input logic [31:0] arg,
                       input logic [31:0] exp_result, input logic [7:0] exp_status,
                       input int lat);
    resp_t r;
    @(negedge clk);
    r.name = name;
    r.result = exp_result;
    r.status = exp_status;
    r.lat = lat;
    r.issue = cycle;
    resp_q.push_back(r);
    arg_in = arg;
    cmd_in = cmd;
  endtask

  task automatic wait_ack(input string name);
    int start;
    start = acks_seen;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (acks_seen != start) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL %s_ack_timeout: got no ack required an ack within 2000 cycles", name);
  endtask

  task automatic push_bus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input int len);
    bus_t b;
    b.wr = wr;
    b.addr = addr;
    b.data = data;
    b.len = len;
    bus_q.push_back(b);
  endtask

  task automatic run(input string name, input logic [7:0] cmd, input logic [31:0] arg,
                     input logic [31:0] exp_result, input logic [7:0] exp_status,
                     input int lat);
    issue(name, cmd, arg, exp_result, exp_status, lat);
    wait_ack(name);
  endtask

  initial begin
    regw_t rw;
    int waited;

    repeat (2) @(negedge clk);
    check("rst_result", 64'(result_out), 64'd0);
    check("rst_status", 64'(status_out), 64'd0);
    check("rst_ctrl", 64'({m_read, m_write, dbg_halt_req, dbg_step_req, dbg_reg_we, dbg_reg_idx}), 64'd0);
    check("rst_addr_data", {m_address, m_writedata}, 64'd0);
    check("rst_reg_wdata", 64'(dbg_reg_wdata), 64'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_accept_after_reset", 64'(status_out), 64'd0);

    run("nop", 8'h80, 32'd0, 32'd0, 8'h80, 2);
    run("set_addr", 8'h04, 32'h0000_1003, 32'h0000_1000, 8'h00, 2);

    push_bus(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4);
    stall_left = 3;
    run("wr_mem", 8'h85, 32'hDEAD_BEEF, 32'h0000_1000, 8'h80, 6);

    push_bus(1'b0, 32'h0000_1004, 32'd0, 1);
    run("rd_mem", 8'h06, 32'd0, 32'hA5A5_1004, 8'h00, 3);

    run("rd_reg_nohalt", 8'h87, 32'd5, 32'hA5A5_1004, 8'h82, 2);
    check("rd_reg_nohalt_idx", 64'(dbg_reg_idx), 64'd0);

    run("halt", 8'h01, 32'd0, 32'hA5A5_1004, 8'h04, 5);
    check("halt_req", 64'(dbg_halt_req), 64'd1);

    run("rd_reg", 8'h87, 32'd5, 32'h0000_1234, 8'h84, 3);
    check("rd_reg_idx", 64'(dbg_reg_idx), 64'd5);

    push_bus(1'b0, 32'h0000_1008, 32'd0, 255);
    stall_left = 100000;
    run("rd_timeout", 8'h06, 32'd0, 32'h0000_1234, 8'h06, 257);
    stall_left = 0;

    push_bus(1'b0, 32'h0000_1008, 32'd0, 1);
    run("rd_mem2", 8'h86, 32'd0, 32'hA5A5_1008, 8'h84, 3);

    step_hi = 0;
    issue("step", 8'h03, 32'd0, 32'hA5A5_1008, 8'h04, 7);
    @(negedge clk);
    cmd_in = 8'h83;
    @(negedge clk);
    cmd_in = 8'h03;
    wait_ack("step");
    repeat (5) @(negedge clk);
    check("step_no_second_accept", 64'(status_out), 64'h04);
    check("step_pulse_cycles", 64'(step_hi), 64'd1);

    rw.idx = 5'd3;
    rw.data = 32'hCAFE_F00D;
    regw_q.push_back(rw);
    run("wr_reg", 8'h88, 32'hCAFE_F00D, 32'hA5A5_1008, 8'h84, 2);

    run("bad_op", 8'h09, 32'd0, 32'hA5A5_1008, 8'h06, 2);
    run("resume", 8'h82, 32'd0, 32'hA5A5_1008, 8'h84, 2);
    repeat (6) @(negedge clk);
    check("resumed_status", 64'(status_out), 64'h80);

    push_bus(1'b1, 32'h0000_100C, 32'h1111_1111, -1);
    stall_left = 100000;
    @(negedge clk);
    arg_in = 32'h1111_1111;
    cmd_in = 8'h05;
    waited = 0;
    while (!m_write && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("wr_pending_seen", 64'(m_write), 64'd1);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_m_write", 64'(m_write), 64'd0);
    check("async_rst_status", 64'(status_out), 64'd0);
    check("async_rst_m_read_halt", 64'({m_read, dbg_halt_req}), 64'd0);
    repeat (2) @(negedge clk);
    stall_left = 0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_accept", 64'(status_out), 64'd0);

    push_bus(1'b0, 32'h0000_0000, 32'd0, 1);
    run("rd_after_rst", 8'h86, 32'd0, 32'hA5A5_0000, 8'h80, 3);

    repeat (3) @(negedge clk);
    check("resp_q_drained", 64'(resp_q.size()), 64'd0);
    check("bus_q_drained", 64'(bus_q.size() + regw_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
